nibble_stim_gen: RTL

Stimulus generator and result collector for the nibble equivalence bench: the driving end of the behavioural-vs-structural comparison. It holds both nibble DUT copies and the output checker in reset, then feeds identical pseudo-random 4-bit vectors to both DUTs. It counts every cycle the checker's 1-bit match flag reports a mismatch and ends with a pass/fail verdict. It sits between the bench top and the DUT pair, and its CHECK_IN is driven by the checker's match output.

---
 rtl/nibble_stim_gen.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/nibble_stim_gen.sv
// Stimulus generator and result collector for the nibble equivalence bench.
// Holds the DUT pair in reset, drives LFSR vectors, then counts mismatch cycles.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | DUT pair held in reset, waiting for start_i
// ST_RST_DUT | DUT pair held in reset for DUT_RESET_CYCLES, run state cleared
// ST_RUN     | one LFSR vector per cycle for NUM_VECTORS cycles
// ST_DRAIN   | no stimulus, mismatches still counted for PIPE_LAT cycles
// ST_DONE    | verdict held until the next start_i or reset_i
module nibble_stim_gen #(
  parameter int         NUM_VECTORS      = 64,
  parameter logic [3:0] SEED             = 4'b1001,
  parameter int         DUT_RESET_CYCLES = 2,
  parameter int         PIPE_LAT         = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       check_in_i,
  output logic [3:0] data_in_o,
  output logic       valid_o,
  output logic       dut_reset_l_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [7:0] err_count_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST_DUT = 3'd1,
    ST_RUN     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // An all-zero seed would lock the LFSR, so it is substituted.
  localparam logic [3:0]  SEED_EFF   = (SEED == 4'b0000) ? 4'b0001 : SEED;
  localparam logic [15:0] RST_LOAD   = 16'(DUT_RESET_CYCLES - 1);
  localparam logic [15:0] RUN_LOAD   = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] DRAIN_LOAD = 16'(PIPE_LAT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  lfsr_q, lfsr_d;
  logic [3:0]  data_in_q, data_in_d;
  logic        valid_q, valid_d;
  logic        dut_reset_l_q, dut_reset_l_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [7:0]  err_q, err_d;
  logic        run_entry;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      lfsr_q        <= SEED_EFF;
      data_in_q     <= '0;
      valid_q       <= 1'b0;
      dut_reset_l_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lfsr_q        <= lfsr_d;
      data_in_q     <= data_in_d;
      valid_q       <= valid_d;
      dut_reset_l_q <= dut_reset_l_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_RST_DUT;
          cnt_d   = RST_LOAD;
        end
      end
      ST_RST_DUT: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
          cnt_d   = RUN_LOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they register alongside it.
  always_comb begin
    run_entry     = (state_d == ST_RST_DUT) && (state_q != ST_RST_DUT);
    lfsr_d        = lfsr_q;
    err_d         = err_q;
    data_in_d     = 4'h0;
    valid_d       = (state_d == ST_RUN);
    dut_reset_l_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    busy_d        = (state_d == ST_RST_DUT) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d        = (state_d == ST_DONE);
    if (run_entry) begin
      lfsr_d = SEED_EFF;
    end else if (state_d == ST_RUN) begin
      data_in_d = lfsr_q;
      lfsr_d    = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    end
    if (run_entry) begin
      err_d = '0;
    end else if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !check_in_i
                 && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
    pass_d = done_d && (err_d == '0);
  end

  assign data_in_o     = data_in_q;
  assign valid_o       = valid_q;
  assign dut_reset_l_o = dut_reset_l_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign err_count_o   = err_q;

endmodule
